// File: rtl/lcd_menu_writer_if.sv
// Avalon-MM write bus between the menu writer and the LCD controller.
interface lcd_menu_writer_if;
    logic       address;
    logic       chipselect;
    logic       write;
    logic       read;
    logic       byteenable;
    logic [7:0] writedata;
    logic       waitrequest;

    modport master (
        output address, chipselect, write, read, byteenable, writedata,
        input  waitrequest
    );

    modport slave (
        input  address, chipselect, write, read, byteenable, writedata,
        output waitrequest
    );
endinterface

// File: rtl/lcd_menu_writer.sv
// Menu writer: tracks a menu index from two buttons and redraws the selected
// entry on an Avalon-MM character LCD (clear, line 0, optional line 1).
module lcd_menu_writer #(
    parameter int N_ITEMS  = 4,
    parameter int LINE_LEN = 16,
    parameter int N_LINES  = 1,
    parameter int WRAP     = 1,
    localparam int TA_W    = $clog2(N_ITEMS * N_LINES * LINE_LEN),
    localparam int IW      = $clog2(N_ITEMS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              button_left,
    input  logic              button_right,
    output logic [TA_W-1:0]   text_addr,
    input  logic [7:0]        text_data,
    lcd_menu_writer_if.master av,
    output logic [IW-1:0]     menu_choice,
    output logic              busy,
    output logic              done
);
    localparam int CW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_LINE1 = 8'hC0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_FETCH,
        S_WAIT_ROM,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      data_q, data_d;
    logic            line_q, line_d;
    logic [CW-1:0]   col_q, col_d;
    logic [TA_W-1:0] taddr_q, taddr_d;
    logic [IW-1:0]   menu_q, menu_d;
    logic            pend_q, pend_d;
    logic            left_q, right_q;

    logic rise_l, rise_r, accept, restart, wr_ok;

    // ROM address of one character of the currently selected entry
    function automatic logic [TA_W-1:0] char_addr(input logic [IW-1:0] mc,
                                                  input logic ln,
                                                  input logic [CW-1:0] col);
        return TA_W'(mc) * TA_W'(N_LINES * LINE_LEN)
             + TA_W'(ln) * TA_W'(LINE_LEN)
             + TA_W'(col);
    endfunction

    // Button edge detection and menu index update (wrap or saturate)
    always_comb begin
        rise_l = button_left  & ~left_q;
        rise_r = button_right & ~right_q;
        accept = rise_l ^ rise_r;
        menu_d = menu_q;
        if (rise_r && !rise_l) begin
            if (menu_q == IW'(N_ITEMS - 1))
                menu_d = (WRAP != 0) ? '0 : menu_q;
            else
                menu_d = menu_q + IW'(1);
        end else if (rise_l && !rise_r) begin
            if (menu_q == '0)
                menu_d = (WRAP != 0) ? IW'(N_ITEMS - 1) : menu_q;
            else
                menu_d = menu_q - IW'(1);
        end
    end

    // Refresh sequencer: next state, character counters and write contents
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        line_d  = line_q;
        col_d   = col_q;
        taddr_d = taddr_q;
        restart = 1'b0;
        wr_ok   = !av.waitrequest;
        case (state_q)
            S_IDLE: begin
                if (pend_q) restart = 1'b1;
            end
            S_CMD: begin
                if (wr_ok) begin
                    if (pend_q) begin
                        restart = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        taddr_d = char_addr(menu_q, line_q, col_q);
                    end
                end
            end
            S_FETCH: begin
                if (pend_q) restart = 1'b1;
                else        state_d = S_WAIT_ROM;
            end
            S_WAIT_ROM: begin
                if (pend_q) begin
                    restart = 1'b1;
                end else begin
                    data_d  = text_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_ok) begin
                    if (pend_q) begin
                        restart = 1'b1;
                    end else if (col_q != CW'(LINE_LEN - 1)) begin
                        col_d   = col_q + CW'(1);
                        taddr_d = char_addr(menu_q, line_q, col_q + CW'(1));
                        state_d = S_FETCH;
                    end else if ((N_LINES == 2) && !line_q) begin
                        cmd_d   = CMD_LINE1;
                        line_d  = 1'b1;
                        col_d   = '0;
                        state_d = S_CMD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every (re)start begins with a display clear from column 0 of line 0;
        // characters are fetched only after this, so pending can be consumed here.
        if (restart) begin
            state_d = S_CMD;
            cmd_d   = CMD_CLEAR;
            line_d  = 1'b0;
            col_d   = '0;
        end

        if (restart)     pend_d = 1'b0;
        else if (accept) pend_d = 1'b1;
        else             pend_d = pend_q;
    end

    // Control state; pending starts set so reset release redraws entry 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cmd_q   <= CMD_CLEAR;
            line_q  <= 1'b0;
            col_q   <= '0;
            taddr_q <= '0;
            menu_q  <= '0;
            pend_q  <= 1'b1;
            left_q  <= 1'b0;
            right_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            line_q  <= line_d;
            col_q   <= col_d;
            taddr_q <= taddr_d;
            menu_q  <= menu_d;
            pend_q  <= pend_d;
            left_q  <= button_left;
            right_q <= button_right;
        end
    end

    // Character holding register; only observed while in WRITE
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    // Bus strobes decode straight from state so reset drops write at once
    assign av.write      = (state_q == S_CMD) || (state_q == S_WRITE);
    assign av.chipselect = av.write;
    assign av.address    = (state_q == S_WRITE);
    assign av.writedata  = (state_q == S_CMD)   ? cmd_q  :
                           (state_q == S_WRITE) ? data_q : 8'h00;
    assign av.read       = 1'b0;
    assign av.byteenable = 1'b1;

    assign text_addr   = taddr_q;
    assign menu_choice = menu_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
endmodule

// File: tb/tb_lcd_menu_writer.sv
// Directed bench for lcd_menu_writer: three instances cover the default
// one-line layout, a two-line layout and a saturating (WRAP=0) menu.
module tb_lcd_menu_writer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic bl_a = 1'b0, br_a = 1'b0, bl_b = 1'b0, br_b = 1'b0, bl_c = 1'b0, br_c = 1'b0;
    logic [5:0] ta_a, ta_b;
    logic [2:0] ta_c;
    logic [7:0] rom_a, rom_b, rom_c;
    logic [1:0] mc_a, mc_b, mc_c;
    logic busy_a, busy_b, busy_c, done_a, done_b, done_c;

    lcd_menu_writer_if bus_a ();
    lcd_menu_writer_if bus_b ();
    lcd_menu_writer_if bus_c ();

    lcd_menu_writer dut_a (
        .clk(clk), .reset_n(rst_a), .button_left(bl_a), .button_right(br_a),
        .text_addr(ta_a), .text_data(rom_a), .av(bus_a.master),
        .menu_choice(mc_a), .busy(busy_a), .done(done_a));

    lcd_menu_writer #(.N_LINES(2), .LINE_LEN(8)) dut_b (
        .clk(clk), .reset_n(rst_b), .button_left(bl_b), .button_right(br_b),
        .text_addr(ta_b), .text_data(rom_b), .av(bus_b.master),
        .menu_choice(mc_b), .busy(busy_b), .done(done_b));

    lcd_menu_writer #(.WRAP(0), .LINE_LEN(2)) dut_c (
        .clk(clk), .reset_n(rst_c), .button_left(bl_c), .button_right(br_c),
        .text_addr(ta_c), .text_data(rom_c), .av(bus_c.master),
        .menu_choice(mc_c), .busy(busy_c), .done(done_c));

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] log_a[$], log_b[$], log_c[$];
    int done_cnt_a = 0, done_cnt_b = 0, done_cnt_c = 0;
    int perr_a = 0, perr_b = 0, perr_c = 0;

    function automatic logic [7:0] rom_f(input int a);
        return 8'(a * 7 + 3);
    endfunction

    // Character ROMs with one cycle of read latency
    always @(posedge clk) begin
        rom_a <= rom_f(32'(ta_a));
        rom_b <= rom_f(32'(ta_b));
        rom_c <= rom_f(32'(ta_c));
    end

    // Bus monitors: log each write that completes at the coming edge
    always @(negedge clk) begin
        if (bus_a.write === 1'b1 && bus_a.waitrequest === 1'b0) log_a.push_back({bus_a.address, bus_a.writedata});
        if (bus_b.write === 1'b1 && bus_b.waitrequest === 1'b0) log_b.push_back({bus_b.address, bus_b.writedata});
        if (bus_c.write === 1'b1 && bus_c.waitrequest === 1'b0) log_c.push_back({bus_c.address, bus_c.writedata});
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
        if (done_c) done_cnt_c <= done_cnt_c + 1;
        if (bus_a.chipselect !== bus_a.write || bus_a.read !== 1'b0 || bus_a.byteenable !== 1'b1 ||
            (bus_a.write === 1'b0 && bus_a.writedata !== 8'h00)) perr_a <= perr_a + 1;
        if (bus_b.chipselect !== bus_b.write || bus_b.read !== 1'b0 || bus_b.byteenable !== 1'b1 ||
            (bus_b.write === 1'b0 && bus_b.writedata !== 8'h00)) perr_b <= perr_b + 1;
        if (bus_c.chipselect !== bus_c.write || bus_c.read !== 1'b0 || bus_c.byteenable !== 1'b1 ||
            (bus_c.write === 1'b0 && bus_c.writedata !== 8'h00)) perr_c <= perr_c + 1;
    end

    task automatic wait_done(input int which, input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if ((which == 0 && done_cnt_a >= target) || (which == 1 && done_cnt_b >= target) ||
                (which == 2 && done_cnt_c >= target)) ok = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic press(input int which, input logic l, input logic r);
        @(posedge clk); #1;
        case (which)
            0: begin bl_a = l; br_a = r; end
            1: begin bl_b = l; br_b = r; end
            default: begin bl_c = l; br_c = r; end
        endcase
        @(posedge clk); #1;
        bl_a = 1'b0; br_a = 1'b0; bl_b = 1'b0; br_b = 1'b0; bl_c = 1'b0; br_c = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus_a.waitrequest = 1'b0; bus_b.waitrequest = 1'b0; bus_c.waitrequest = 1'b0;
        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus_a.write !== 1'b0) begin n_fail++; $display("FAIL reset_write_a: got %b want 0", bus_a.write); end
        n_checks++; if (bus_a.chipselect !== 1'b0) begin n_fail++; $display("FAIL reset_cs_a: got %b want 0", bus_a.chipselect); end
        n_checks++; if (bus_a.address !== 1'b0) begin n_fail++; $display("FAIL reset_addr_a: got %b want 0", bus_a.address); end
        n_checks++; if (bus_a.writedata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata_a: got %h want 00", bus_a.writedata); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done_a: got %b want 0", done_a); end
        n_checks++; if (ta_a !== 6'd0) begin n_fail++; $display("FAIL reset_taddr_a: got %0d want 0", ta_a); end
        n_checks++; if (mc_a !== 2'd0) begin n_fail++; $display("FAIL reset_menu_a: got %0d want 0", mc_a); end
        n_checks++; if (bus_b.write !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_b: got write %b busy %b want 0 0", bus_b.write, busy_b); end
        n_checks++; if (bus_c.write !== 1'b0 || mc_c !== 2'd0) begin n_fail++; $display("FAIL reset_c: got write %b menu %0d want 0 0", bus_c.write, mc_c); end
    endtask

    task automatic test_refresh_one_line();
        int bl, bd; bit ok;
        bl = log_a.size(); bd = done_cnt_a;
        @(posedge clk); #1; rst_a = 1'b1;
        wait_done(0, bd + 1, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL refresh_a_timeout: got no done, want done"); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL refresh_a_busy_after: got %b want 0", busy_a); end
        n_checks++; if (done_cnt_a !== bd + 1) begin n_fail++; $display("FAIL refresh_a_done_count: got %0d want %0d", done_cnt_a - bd, 1); end
        n_checks++; if (log_a.size() !== bl + 17) begin n_fail++; $display("FAIL refresh_a_nwrites: got %0d want 17", log_a.size() - bl); end
        n_checks++; if (log_a[bl] !== {1'b0, 8'h01}) begin n_fail++; $display("FAIL refresh_a_clear: got %h want 001", log_a[bl]); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (log_a[bl + 1 + i] !== {1'b1, rom_f(i)}) begin
                n_fail++; $display("FAIL refresh_a_char%0d: got %h want %h", i, log_a[bl + 1 + i], {1'b1, rom_f(i)});
            end
        end
    endtask

    task automatic test_two_lines();
        int bl, bd; bit ok;
        @(posedge clk); #1; rst_b = 1'b1;
        wait_done(1, done_cnt_b + 1, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL two_lines_first_timeout: got no done, want done"); end
        bl = log_b.size(); bd = done_cnt_b;
        press(1, 1'b0, 1'b1);
        n_checks++; if (mc_b !== 2'd1) begin n_fail++; $display("FAIL two_lines_menu: got %0d want 1", mc_b); end
        wait_done(1, bd + 1, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL two_lines_timeout: got no done, want done"); end
        n_checks++; if (log_b.size() !== bl + 18) begin n_fail++; $display("FAIL two_lines_nwrites: got %0d want 18", log_b.size() - bl); end
        n_checks++; if (log_b[bl] !== {1'b0, 8'h01}) begin n_fail++; $display("FAIL two_lines_clear: got %h want 001", log_b[bl]); end
        n_checks++; if (log_b[bl + 9] !== {1'b0, 8'hC0}) begin n_fail++; $display("FAIL two_lines_line1_cmd: got %h want 0c0", log_b[bl + 9]); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (log_b[bl + 1 + i] !== {1'b1, rom_f(16 + i)}) begin
                n_fail++; $display("FAIL two_lines_l0_char%0d: got %h want %h", i, log_b[bl + 1 + i], {1'b1, rom_f(16 + i)});
            end
            n_checks++;
            if (log_b[bl + 10 + i] !== {1'b1, rom_f(24 + i)}) begin
                n_fail++; $display("FAIL two_lines_l1_char%0d: got %h want %h", i, log_b[bl + 10 + i], {1'b1, rom_f(24 + i)});
            end
        end
    endtask

    task automatic test_wrap();
        int bl, bd; bit ok;
        bl = log_a.size(); bd = done_cnt_a;
        press(0, 1'b1, 1'b0);
        n_checks++; if (mc_a !== 2'd3) begin n_fail++; $display("FAIL wrap_left: got %0d want 3", mc_a); end
        wait_done(0, bd + 1, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_left_timeout: got no done, want done"); end
        n_checks++; if (log_a[bl + 1] !== {1'b1, rom_f(48)}) begin n_fail++; $display("FAIL wrap_left_char0: got %h want %h", log_a[bl + 1], {1'b1, rom_f(48)}); end
        bl = log_a.size(); bd = done_cnt_a;
        press(0, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        n_checks++; if (mc_a !== 2'd3) begin n_fail++; $display("FAIL wrap_both_menu: got %0d want 3", mc_a); end
        n_checks++; if (log_a.size() !== bl || busy_a !== 1'b0) begin n_fail++; $display("FAIL wrap_both_refresh: got %0d writes busy %b want 0 writes busy 0", log_a.size() - bl, busy_a); end
        press(0, 1'b0, 1'b1);
        n_checks++; if (mc_a !== 2'd0) begin n_fail++; $display("FAIL wrap_right: got %0d want 0", mc_a); end
        wait_done(0, bd + 1, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_right_timeout: got no done, want done"); end
    endtask

    task automatic test_saturate();
        int bl, bd; bit ok;
        @(posedge clk); #1; rst_c = 1'b1;
        wait_done(2, done_cnt_c + 1, 100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL sat_first_timeout: got no done, want done"); end
        bl = log_c.size(); bd = done_cnt_c;
        press(2, 1'b1, 1'b0);
        n_checks++; if (mc_c !== 2'd0) begin n_fail++; $display("FAIL sat_left_at_0: got %0d want 0", mc_c); end
        wait_done(2, bd + 1, 100, ok);
        n_checks++; if (!ok || log_c.size() !== bl + 3 || log_c[bl + 1] !== {1'b1, rom_f(0)}) begin
            n_fail++; $display("FAIL sat_left_refresh: got done %b writes %0d want 1 3", ok, log_c.size() - bl);
        end
        for (int k = 0; k < 3; k++) begin
            bl = log_c.size(); bd = done_cnt_c;
            press(2, 1'b0, 1'b1);
            wait_done(2, bd + 1, 100, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL sat_step%0d_timeout: got no done, want done", k); end
        end
        n_checks++; if (mc_c !== 2'd3) begin n_fail++; $display("FAIL sat_right_to_3: got %0d want 3", mc_c); end
        n_checks++; if (log_c[bl + 1] !== {1'b1, rom_f(6)} || log_c[bl + 2] !== {1'b1, rom_f(7)}) begin
            n_fail++; $display("FAIL sat_entry3_chars: got %h %h want %h %h", log_c[bl + 1], log_c[bl + 2], {1'b1, rom_f(6)}, {1'b1, rom_f(7)});
        end
        bd = done_cnt_c;
        press(2, 1'b0, 1'b1);
        n_checks++; if (mc_c !== 2'd3) begin n_fail++; $display("FAIL sat_right_at_3: got %0d want 3", mc_c); end
        wait_done(2, bd + 1, 100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL sat_right_at_3_refresh: got no done, want done"); end
    endtask

    task automatic test_stall();
        int bl, bd; bit ok, seen; logic a0; logic [7:0] d0;
        @(posedge clk); #1; rst_a = 1'b0; bus_a.waitrequest = 1'b1;
        @(posedge clk); #1; rst_a = 1'b1;
        bl = log_a.size(); bd = done_cnt_a;
        for (int k = 0; k < 17; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (bus_a.write === 1'b1) seen = 1'b1;
            end
            n_checks++; if (!seen) begin n_fail++; $display("FAIL stall_write%0d_timeout: got no write, want write", k); end
            if (!seen) break;
            if (k == 2) begin
                a0 = bus_a.address; d0 = bus_a.writedata;
                n_checks++; if ({a0, d0} !== {1'b1, rom_f(1)}) begin n_fail++; $display("FAIL stall_third_write: got %h want %h", {a0, d0}, {1'b1, rom_f(1)}); end
                for (int c = 0; c < 5; c++) begin
                    if (c == 4) begin @(posedge clk); #1; bus_a.waitrequest = 1'b0; end
                    @(negedge clk);
                    n_checks++;
                    if (bus_a.write !== 1'b1 || bus_a.address !== a0 || bus_a.writedata !== d0) begin
                        n_fail++; $display("FAIL stall_hold%0d: got w%b a%b d%h want w1 a%b d%h", c, bus_a.write, bus_a.address, bus_a.writedata, a0, d0);
                    end
                end
                @(posedge clk); #1; bus_a.waitrequest = 1'b1;
                @(negedge clk);
                n_checks++; if (bus_a.write !== 1'b0 || log_a.size() !== bl + 3) begin
                    n_fail++; $display("FAIL stall_complete: got write %b writes %0d want 0 3", bus_a.write, log_a.size() - bl);
                end
            end else begin
                @(posedge clk); #1; bus_a.waitrequest = 1'b0;
                @(posedge clk); #1; bus_a.waitrequest = 1'b1;
            end
        end
        bus_a.waitrequest = 1'b0;
        wait_done(0, bd + 1, 50, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_done_timeout: got no done, want done"); end
        n_checks++; if (log_a.size() !== bl + 17 || log_a[bl] !== {1'b0, 8'h01} || log_a[bl + 3] !== {1'b1, rom_f(2)}) begin
            n_fail++; $display("FAIL stall_sequence: got %0d writes first %h fourth %h", log_a.size() - bl, log_a[bl], log_a[bl + 3]);
        end
    endtask

    task automatic test_restart();
        int bl, bd; bit ok, seen;
        @(posedge clk); #1; rst_a = 1'b0;
        @(posedge clk); #1; rst_a = 1'b1;
        bl = log_a.size(); bd = done_cnt_a;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin @(negedge clk); if (ta_a === 6'd4) seen = 1'b1; end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL restart_fetch4_timeout: got no fetch, want fetch of 4"); end
        @(posedge clk); #1; bus_a.waitrequest = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); if (bus_a.write === 1'b1) seen = 1'b1; end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL restart_write5_timeout: got no write, want write"); end
        @(posedge clk); #1; br_a = 1'b1;
        @(posedge clk); #1; br_a = 1'b0; bus_a.waitrequest = 1'b0;
        wait_done(0, bd + 1, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL restart_done_timeout: got no done, want done"); end
        repeat (5) @(negedge clk);
        n_checks++; if (done_cnt_a !== bd + 1) begin n_fail++; $display("FAIL restart_done_pulses: got %0d want 1", done_cnt_a - bd); end
        n_checks++; if (mc_a !== 2'd1) begin n_fail++; $display("FAIL restart_menu: got %0d want 1", mc_a); end
        n_checks++; if (log_a.size() !== bl + 23) begin n_fail++; $display("FAIL restart_nwrites: got %0d want 23", log_a.size() - bl); end
        n_checks++; if (log_a[bl + 5] !== {1'b1, rom_f(4)}) begin n_fail++; $display("FAIL restart_inflight: got %h want %h", log_a[bl + 5], {1'b1, rom_f(4)}); end
        n_checks++; if (log_a[bl + 6] !== {1'b0, 8'h01}) begin n_fail++; $display("FAIL restart_clear: got %h want 001", log_a[bl + 6]); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (log_a[bl + 7 + i] !== {1'b1, rom_f(16 + i)}) begin
                n_fail++; $display("FAIL restart_char%0d: got %h want %h", i, log_a[bl + 7 + i], {1'b1, rom_f(16 + i)});
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int bl, bd; bit ok, seen;
        bus_a.waitrequest = 1'b1;
        press(0, 1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus_a.write === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rstmid_write_timeout: got no write, want write"); end
        #2; rst_a = 1'b0;
        #1;
        n_checks++; if (bus_a.write !== 1'b0 || bus_a.chipselect !== 1'b0 || bus_a.writedata !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_async_drop: got w%b cs%b d%h want w0 cs0 d00", bus_a.write, bus_a.chipselect, bus_a.writedata);
        end
        n_checks++; if (mc_a !== 2'd0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: got menu %0d busy %b want 0 0", mc_a, busy_a); end
        @(posedge clk); #1; bus_a.waitrequest = 1'b0;
        @(posedge clk); #1; rst_a = 1'b1;
        bl = log_a.size(); bd = done_cnt_a;
        wait_done(0, bd + 1, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_done_timeout: got no done, want done"); end
        n_checks++; if (log_a.size() !== bl + 17 || log_a[bl] !== {1'b0, 8'h01}) begin
            n_fail++; $display("FAIL rstmid_sequence: got %0d writes first %h want 17 001", log_a.size() - bl, log_a[bl]);
        end
        n_checks++; if (log_a[bl + 1] !== {1'b1, rom_f(0)} || log_a[bl + 16] !== {1'b1, rom_f(15)}) begin
            n_fail++; $display("FAIL rstmid_entry0: got %h %h want %h %h", log_a[bl + 1], log_a[bl + 16], {1'b1, rom_f(0)}, {1'b1, rom_f(15)});
        end
    endtask

    task automatic test_bus_rules();
        n_checks++;
        if (perr_a + perr_b + perr_c !== 0) begin
            n_fail++; $display("FAIL bus_rules: got %0d/%0d/%0d violating cycles want 0", perr_a, perr_b, perr_c);
        end
    endtask

    initial begin
        test_reset();
        test_refresh_one_line();
        test_two_lines();
        test_wrap();
        test_saturate();
        test_stall();
        test_restart();
        test_reset_mid_write();
        test_bus_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lcd_menu_writer.md
LCD_MENU_WRITER -- requirements
Module: lcd_menu_writer

Interface
REQ-001 Parameter N_ITEMS, default 4: number of menu entries, range 2..8.
REQ-002 Parameter LINE_LEN, default 16: characters written per display line, range 1..40.
REQ-003 Parameter N_LINES, default 1: display lines per entry, 1 or 2.
REQ-004 Parameter WRAP, default 1: 1 means menu index wraps at the ends, 0 means it saturates.
REQ-005 Derived TA_W = clog2(N_ITEMS*N_LINES*LINE_LEN); IW = clog2(N_ITEMS).
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 button_left  input  1  level, synchronous to clk, active-high; its rising edge selects the previous entry.
REQ-009 button_right  input  1  level, active-high; its rising edge selects the next entry.
REQ-010 text_addr  output  TA_W  character ROM address.
REQ-011 text_data  input  8  ROM character; valid exactly 1 cycle after text_addr.
REQ-012 address  output  1  Avalon-MM address to LCD controller; 0 = command, 1 = data.
REQ-013 chipselect, write  output  1 each  Avalon-MM strobes; chipselect equals write.
REQ-014 read  output  1  tied 0; byteenable  output  1  tied 1.
REQ-015 writedata  output  8  Avalon-MM write data; 0 when write is 0.
REQ-016 waitrequest  input  1  Avalon-MM slave stall.
REQ-017 menu_choice  output  IW  currently selected entry.
REQ-018 busy  output  1  high while a refresh sequence is in progress.
REQ-019 done  output  1  one-cycle pulse when a refresh completes without abort.

Function
REQ-020 Button edges are detected internally; an edge is a 0->1 transition between consecutive samples.
REQ-021 Right edge: menu_choice+1; at N_ITEMS-1 it goes to 0 if WRAP=1, else holds.
REQ-022 Left edge: menu_choice-1; at 0 it goes to N_ITEMS-1 if WRAP=1, else holds.
REQ-023 Left and right edges in the same cycle: menu_choice unchanged, no refresh requested.
REQ-024 Any accepted edge that changes or keeps menu_choice sets refresh-pending; the update takes effect on the next clock.
REQ-025 Refresh sequence, in order:
- CLEAR: command 0x01, address 0.
- Line 0: LINE_LEN data writes, address 1.
- If N_LINES=2: command 0xC0 (address 0), then line 1: LINE_LEN data writes.
REQ-026 Total writes per refresh: 1 + N_LINES*LINE_LEN + (N_LINES-1), e.g. 18 for N_LINES=2, LINE_LEN=8.
REQ-027 Character of line l, column c comes from text_addr = menu_choice*N_LINES*LINE_LEN + l*LINE_LEN + c.
REQ-028 States: IDLE, CMD, FETCH, WAIT_ROM, WRITE, DONE.
- IDLE -> CMD when refresh-pending; busy rises the same cycle the state leaves IDLE.
- CMD: drives the command write and holds it until waitrequest=0, then -> FETCH.
- FETCH: presents text_addr, 1 cycle -> WAIT_ROM.
- WAIT_ROM: registers text_data, 1 cycle -> WRITE.
- WRITE: holds the data write until waitrequest=0.
- After WRITE: next column -> FETCH; line end with a line remaining -> CMD(0xC0); last character -> DONE.
- DONE: pulses done, 1 cycle -> IDLE.
REQ-029 While write=1 and waitrequest=1, address, writedata and write are held stable.
REQ-030 A write completes in the first cycle where write=1 and waitrequest=0; the minimum is 1 cycle.
REQ-031 An edge during a refresh sets refresh-pending and updates menu_choice immediately, without corrupting any in-flight write.
- When the in-flight write completes, the FSM returns to CMD and restarts with CLEAR; no done pulse is issued.
- If no write is in flight (FETCH/WAIT_ROM), the restart happens on the next cycle.
REQ-032 Refresh-pending clears when CMD(CLEAR) is entered; multiple edges before that produce a single refresh.

Reset
REQ-033 reset_n=0 asynchronously forces: state IDLE, menu_choice 0, write/chipselect/address/writedata 0, busy 0, done 0, text_addr 0, edge history 0.
REQ-034 refresh-pending resets to 1, so the first cycle after release starts a refresh of entry 0.
REQ-035 reset_n asserted mid-write drops write immediately, with no completion required.

Verification
REQ-036 Reset release, N_LINES=1, LINE_LEN=16, waitrequest=0: writes are 0x01@a0, then ROM[0..15]@a1; done pulses once; busy low afterwards.
REQ-037 N_LINES=2, LINE_LEN=8, menu_choice 1: writes are 0x01, chars from addr 16..23, 0xC0@a0, chars from addr 24..31 (18 writes total).
REQ-038 waitrequest held high 5 cycles on the third write: outputs stable all 5 cycles, and the write completes on the cycle waitrequest drops.
REQ-039 WRAP=1: left at 0 gives 3; WRAP=0: left at 0 stays 0 and right at 3 stays 3; simultaneous left+right gives no change and no refresh.
REQ-040 Right edge during the 5th character write: that write completes, the next write is 0x01, all characters come from entry 1, and there is exactly one done pulse (from the final refresh).
REQ-041 reset_n pulsed low while write=1: write drops asynchronously; after release a full refresh of entry 0 occurs.
